inv_key_schedule: RTL
=====================

Name: inv_key_schedule

Overview:
- Sequential AES-128 inverse key schedule for the decryption datapath.
- Accepts the final round key (round 10) and regenerates the round keys in descending order, 10 down to 0, one per accepted handshake.
- Sits between key storage and the inverse-cipher round logic; only one 128-bit key register is needed instead of a full expanded-key array.

Parameters:
- NUM_ROUNDS, 10, number of key-expansion rounds; the first round key emitted carries this index. Only 10 (AES-128) is supported.
- KEY_BITS, 128, round-key width.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start_valid  input  1  last_key is valid.
- start_ready  output  1  block can accept a new last_key.
- last_key  input  128  round-NUM_ROUNDS key. Word 0 = [127:96]; byte 0 of each word is its MSB.
- abort  input  1  cancels an in-progress sequence.
- rk_valid  output  1  rk_data/rk_round are valid.
- rk_ready  input  1  consumer accepts the current round key.
- rk_data  output  128  current round key.
- rk_round  output  4  round index of rk_data.
- busy  output  1  high in EMIT.

Behaviour:
- One clock; synchronous, active-low reset. On reset_n=0 at a clock edge:
  - state goes to IDLE;
  - key register, rk_data and rk_round go to 0;
  - rk_valid=0, busy=0, start_ready=1 after that edge.
- States: IDLE, EMIT.
- IDLE:
  - start_ready=1, rk_valid=0.
  - On start_valid&start_ready: key_reg<=last_key, round<=NUM_ROUNDS, go to EMIT.
  - First rk_valid is in the next cycle (1-cycle load latency).
- EMIT:
  - start_ready=0, busy=1, rk_valid=1, rk_data=key_reg, rk_round=round.
  - Outputs are stable while rk_ready=0.
  - On rk_valid&rk_ready with round>0: key_reg<=prev(key_reg, round), round<=round-1. The next key is available the following cycle, giving full throughput at one key per cycle.
  - On rk_valid&rk_ready with round==0: go to IDLE. rk_valid=0 the next cycle and start_ready=1 the next cycle, so there is a one-cycle bubble between sequences.
- prev(w, r), with w0..w3 the current words:
  - p3=w3^w2, p2=w2^w1, p1=w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {RCON[r],24'h0}.
  - RotWord maps [b0 b1 b2 b3] to [b1 b2 b3 b0].
  - SubWord applies the forward S-box (the shared sbox table) bytewise.
  - RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36. RCON is indexed by the round being undone, never 0.
  - All operations are XOR on fixed widths; there is no carry.
- abort:
  - In EMIT, abort=1 goes to IDLE next cycle; rk_valid=0 next cycle.
  - abort has priority over a simultaneous handshake: that key counts as accepted but no further keys are generated.
  - abort is ignored in IDLE.
- start_valid during EMIT is ignored, because start_ready=0.
- Reset mid-sequence has priority over abort and the handshake; there is no partial output afterwards.
- rk_round never underflows. The round==0 handshake always exits EMIT.

Optional Feature:
- Macro: INV_KEY_ZEROIZE_EN.
- Defined:
  - key_reg clears to 0 in the cycle after the round-0 handshake or an abort.
  - rk_data and rk_round read 0 whenever rk_valid=0.
- Undefined:
  - key_reg is not cleared.
  - In IDLE, rk_data holds the last emitted (or aborted) key and rk_round its index; they are still qualified by rk_valid=0.

Test Plan:
- FIPS-197 A.1 vector, rk_ready=1 continuously, last_key=d014f9a8c9ee2589e13f0cc8b6630ca6:
  - 11 consecutive rk_valid cycles.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - round 9 = ac7766f319fadc2128d12941575c006e.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Then rk_valid=0 and start_ready=1.
- Backpressure, same key, rk_ready random about 50%: the identical 11-key sequence; rk_data/rk_round unchanged across every stall cycle.
- Abort at round 6 while rk_ready=1: the round-6 key is accepted, rk_valid=0 next cycle, start_ready=1, no round-5 output. A new start then restarts at round 10 with correct keys.
- reset_n=0 for 1 cycle during round 4: next cycle rk_valid=0, busy=0, rk_round=0, rk_data=0, start_ready=1.
- start_valid held high through the last handshake: the new key is not captured until the bubble cycle; the second sequence begins 2 cycles after the round-0 handshake.
- Zeroize check, with and without INV_KEY_ZEROIZE_EN after a completed sequence:
  - Defined: rk_data=0 in IDLE.
  - Undefined: rk_data=2b7e151628aed2a6abf7158809cf4f3c in IDLE.

Source files
------------

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: regenerates round keys 10 down to 0 from the last round key.
// Define INV_KEY_ZEROIZE_EN to clear the key register and outputs whenever rk_valid is low.
module inv_key_schedule #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_BITS   = 128
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [KEY_BITS-1:0] last_key,
  input  logic                abort,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [KEY_BITS-1:0] rk_data,
  output logic [3:0]          rk_round,
  output logic                busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  // Forward AES S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t              state;
  logic [KEY_BITS-1:0] key_reg;
  logic [3:0]          round_reg;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Undo one forward expansion step: recovers round r-1 from round r.
  function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot, sub;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    p3  = w3 ^ w2;
    p2  = w2 ^ w1;
    p1  = w1 ^ w0;
    rot = {p3[23:0], p3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    p0  = w0 ^ sub ^ {rcon(r), 24'h000000};
    prev_key = {p0, p1, p2, p3};
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      key_reg     <= '0;
      round_reg   <= '0;
      rk_valid    <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            key_reg     <= last_key;
            round_reg   <= 4'(NUM_ROUNDS);
            rk_valid    <= 1'b1;
            busy        <= 1'b1;
            start_ready <= 1'b0;
            state       <= EMIT;
          end
        end
        EMIT: begin
          // Abort wins over the handshake; the round-0 handshake always ends the sequence.
          if (abort || (rk_ready && round_reg == 4'd0)) begin
            rk_valid    <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
`ifdef INV_KEY_ZEROIZE_EN
            key_reg     <= '0;
            round_reg   <= '0;
`endif
          end else if (rk_ready) begin
            key_reg   <= prev_key(key_reg, round_reg);
            round_reg <= round_reg - 4'd1;
          end
        end
        default: begin
          state       <= IDLE;
          rk_valid    <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

  assign rk_data  = key_reg;
  assign rk_round = round_reg;

endmodule
